// File: rtl/id_stage.sv
// id_stage: instruction decode with integrated ID/EX pipeline register,
// internal register file and load-use hazard detection.
// Optional feature macro: ID_WB_BYPASS_EN -- when defined, a write-back to
// a register being read in the same cycle is forwarded to the read port
// (write-first). When undefined, reads return the previously stored value.

module id_stage #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int IMM_W = 16,
    localparam int RAW  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     if_id_instr,
    input  logic            if_id_valid,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            id_ex_valid,
    output logic [31:0]     id_ex_instr,
    output logic [XLEN-1:0] id_ex_a,
    output logic [XLEN-1:0] id_ex_b,
    output logic [XLEN-1:0] id_ex_simm,
    output logic [XLEN-1:0] id_ex_zimm,
    output logic [RAW-1:0]  id_ex_rs,
    output logic [RAW-1:0]  id_ex_rt,
    output logic [RAW-1:0]  id_ex_rd,
    output logic [8:0]      id_ex_ctrl
);

    // Opcodes recognised by the decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // Control bundle layout: {RegDst, ALUOp[1:0], ALUSrcB[1:0], MemRead, MemWrite, RegWrite, MemtoReg}
    localparam int CTRL_MEMREAD = 3;

    // Decoded fields of the instruction currently sitting in IF/ID
    logic [5:0]       opcode;
    logic [RAW-1:0]   rsIdx;
    logic [RAW-1:0]   rtIdx;
    logic [RAW-1:0]   rdIdx;
    logic [IMM_W-1:0] immField;
    logic [XLEN-1:0]  simmExt;
    logic [XLEN-1:0]  zimmExt;
    logic [8:0]       ctrlDec;
    logic             usesRt;
    logic [XLEN-1:0]  opA;
    logic [XLEN-1:0]  opB;
    logic             bubble;

    // Register file storage
    logic [XLEN-1:0]  regs_q [NREG];

    // ID/EX pipeline register and its next-state values
    logic             exValid_q, exValid_d;
    logic [31:0]      exInstr_q, exInstr_d;
    logic [XLEN-1:0]  exA_q, exA_d;
    logic [XLEN-1:0]  exB_q, exB_d;
    logic [XLEN-1:0]  exSimm_q, exSimm_d;
    logic [XLEN-1:0]  exZimm_q, exZimm_d;
    logic [RAW-1:0]   exRs_q, exRs_d;
    logic [RAW-1:0]   exRt_q, exRt_d;
    logic [RAW-1:0]   exRd_q, exRd_d;
    logic [8:0]       exCtrl_q, exCtrl_d;

    assign opcode   = if_id_instr[31:26];
    assign rsIdx    = RAW'(if_id_instr[25:21]);
    assign rtIdx    = RAW'(if_id_instr[20:16]);
    assign rdIdx    = RAW'(if_id_instr[15:11]);
    assign immField = if_id_instr[IMM_W-1:0];
    assign simmExt  = XLEN'($signed(immField));
    assign zimmExt  = XLEN'(immField);

    // Opcode decode into the control bundle and the "reads rt" flag
    always_comb begin
        ctrlDec = '0;
        usesRt  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrlDec = 9'b1_10_00_0_0_1_0;
                usesRt  = 1'b1;
            end
            OP_LW:   ctrlDec = 9'b0_00_01_1_0_1_1;
            OP_SW: begin
                ctrlDec = 9'b0_00_01_0_1_0_0;
                usesRt  = 1'b1;
            end
            OP_ADDI: ctrlDec = 9'b0_00_01_0_0_1_0;
            OP_ANDI, OP_ORI: ctrlDec = 9'b0_11_10_0_0_1_0;
            OP_BEQ: begin
                ctrlDec = 9'b0_01_00_0_0_0_0;
                usesRt  = 1'b1;
            end
            default: ctrlDec = '0;
        endcase
    end

    // Combinational operand read; r0 is hardwired to zero and never forwarded
    always_comb begin
        opA = '0;
        opB = '0;
        if (rsIdx != '0) opA = regs_q[rsIdx];
        if (rtIdx != '0) opB = regs_q[rtIdx];
`ifdef ID_WB_BYPASS_EN
        if (wb_we && (wb_rd != '0) && (wb_rd == rsIdx)) opA = wb_data;
        if (wb_we && (wb_rd != '0) && (wb_rd == rtIdx)) opB = wb_data;
`endif
    end

    // Load-use hazard: the load in EX targets a register this instruction reads.
    // A flush kills the instruction in ID, so there is nothing to hold.
    assign stall = if_id_valid & exValid_q & exCtrl_q[CTRL_MEMREAD] & (exRt_q != '0)
                 & ((exRt_q == rsIdx) | (usesRt & (exRt_q == rtIdx))) & ~flush;

    assign bubble = stall | flush | ~if_id_valid;

    // Next ID/EX contents: an all-zero bubble or the freshly decoded instruction
    always_comb begin
        exValid_d = 1'b0;
        exInstr_d = '0;
        exA_d     = '0;
        exB_d     = '0;
        exSimm_d  = '0;
        exZimm_d  = '0;
        exRs_d    = '0;
        exRt_d    = '0;
        exRd_d    = '0;
        exCtrl_d  = '0;
        if (!bubble) begin
            exValid_d = 1'b1;
            exInstr_d = if_id_instr;
            exA_d     = opA;
            exB_d     = opB;
            exSimm_d  = simmExt;
            exZimm_d  = zimmExt;
            exRs_d    = rsIdx;
            exRt_d    = rtIdx;
            exRd_d    = rdIdx;
            exCtrl_d  = ctrlDec;
        end
    end

    // Register file write port; writes to r0 are discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wb_we && (wb_rd != '0)) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exValid_q <= 1'b0;
            exInstr_q <= '0;
            exA_q     <= '0;
            exB_q     <= '0;
            exSimm_q  <= '0;
            exZimm_q  <= '0;
            exRs_q    <= '0;
            exRt_q    <= '0;
            exRd_q    <= '0;
            exCtrl_q  <= '0;
        end else begin
            exValid_q <= exValid_d;
            exInstr_q <= exInstr_d;
            exA_q     <= exA_d;
            exB_q     <= exB_d;
            exSimm_q  <= exSimm_d;
            exZimm_q  <= exZimm_d;
            exRs_q    <= exRs_d;
            exRt_q    <= exRt_d;
            exRd_q    <= exRd_d;
            exCtrl_q  <= exCtrl_d;
        end
    end

    assign id_ex_valid = exValid_q;
    assign id_ex_instr = exInstr_q;
    assign id_ex_a     = exA_q;
    assign id_ex_b     = exB_q;
    assign id_ex_simm  = exSimm_q;
    assign id_ex_zimm  = exZimm_q;
    assign id_ex_rs    = exRs_q;
    assign id_ex_rt    = exRt_q;
    assign id_ex_rd    = exRd_q;
    assign id_ex_ctrl  = exCtrl_q;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage with default parameters.
// Expected values are hand-computed; the same-cycle write/read result follows
// ID_WB_BYPASS_EN if the bench is compiled with it.

module tb_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        id_ex_valid;
    logic [31:0] id_ex_instr;
    logic [31:0] id_ex_a;
    logic [31:0] id_ex_b;
    logic [31:0] id_ex_simm;
    logic [31:0] id_ex_zimm;
    logic [4:0]  id_ex_rs;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_rd;
    logic [8:0]  id_ex_ctrl;

    int testsRun  = 0;
    int testsFail = 0;

    logic [31:0] expSameCycle;

    // Hand-assembled instructions and expected control bundles
    localparam logic [31:0] ADD_R3_R5_R0 = 32'h00A01820;
    localparam logic [31:0] LW_R2_0_R1   = 32'h8C220000;
    localparam logic [31:0] ADD_R4_R2_R2 = 32'h00422020;
    localparam logic [31:0] ADDI_R6_M1   = 32'h2006FFFF;
    localparam logic [31:0] ADDI_R2_R0_5 = 32'h20020005;
    localparam logic [31:0] UNKNOWN_3F   = 32'hFC000000;
    localparam logic [31:0] ORI_R7_R5    = 32'h34A78000;
    localparam logic [31:0] SW_R3_R5     = 32'hACA30004;
    localparam logic [31:0] BEQ_R5_R5    = 32'h10A50000;
    localparam logic [31:0] ADD_R8_R7_R0 = 32'h00E04020;
    localparam logic [31:0] ADD_R9_R0_R0 = 32'h00004820;

    localparam logic [8:0] CTRL_R    = 9'b110000010;
    localparam logic [8:0] CTRL_LW   = 9'b000011011;
    localparam logic [8:0] CTRL_SW   = 9'b000010100;
    localparam logic [8:0] CTRL_ADDI = 9'b000010010;
    localparam logic [8:0] CTRL_LOGI = 9'b011100010;
    localparam logic [8:0] CTRL_BEQ  = 9'b001000000;

    id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .flush       (flush),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .stall       (stall),
        .id_ex_valid (id_ex_valid),
        .id_ex_instr (id_ex_instr),
        .id_ex_a     (id_ex_a),
        .id_ex_b     (id_ex_b),
        .id_ex_simm  (id_ex_simm),
        .id_ex_zimm  (id_ex_zimm),
        .id_ex_rs    (id_ex_rs),
        .id_ex_rt    (id_ex_rt),
        .id_ex_rd    (id_ex_rd),
        .id_ex_ctrl  (id_ex_ctrl)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive every DUT input in one go
    task automatic applyStimulus(input logic [31:0] instr, input logic valid, input logic fl,
                                 input logic we, input logic [4:0] rd, input logic [31:0] data);
        if_id_instr = instr;
        if_id_valid = valid;
        flush       = fl;
        wb_we       = we;
        wb_rd       = rd;
        wb_data     = data;
    endtask

    // Single comparison point: counts and reports any disagreement
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance past one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef ID_WB_BYPASS_EN
        expSameCycle = 32'h12345678;
`else
        expSameCycle = 32'h11111111;
`endif
        rst = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #2;
        checkOutput("reset_valid", id_ex_valid, 0);
        checkOutput("reset_ctrl", id_ex_ctrl, 0);
        checkOutput("reset_stall", stall, 0);
        rst = 1'b0;

        // Preload r5, r2, r7 through the write-back port
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h00000022);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h11111111);
        tick();
        checkOutput("idle_bubble_valid", id_ex_valid, 0);

        // add r3,r5,r0
        applyStimulus(ADD_R3_R5_R0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("add_valid", id_ex_valid, 1);
        checkOutput("add_instr", id_ex_instr, ADD_R3_R5_R0);
        checkOutput("add_a", id_ex_a, 32'hDEADBEEF);
        checkOutput("add_b", id_ex_b, 0);
        checkOutput("add_ctrl", id_ex_ctrl, CTRL_R);
        checkOutput("add_rs", id_ex_rs, 5);
        checkOutput("add_rd", id_ex_rd, 3);

        // lw r2,0(r1) then add r4,r2,r2: one-cycle stall, bubble, then the add
        applyStimulus(LW_R2_0_R1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("lw_ctrl", id_ex_ctrl, CTRL_LW);
        checkOutput("lw_rt", id_ex_rt, 2);
        applyStimulus(ADD_R4_R2_R2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("loaduse_stall", stall, 1);
        tick();
        checkOutput("bubble_valid", id_ex_valid, 0);
        checkOutput("bubble_ctrl", id_ex_ctrl, 0);
        checkOutput("bubble_instr", id_ex_instr, 0);
        checkOutput("bubble_a", id_ex_a, 0);
        checkOutput("stall_drops", stall, 0);
        tick();
        checkOutput("held_add_valid", id_ex_valid, 1);
        checkOutput("held_add_instr", id_ex_instr, ADD_R4_R2_R2);
        checkOutput("held_add_a", id_ex_a, 32'h22);
        checkOutput("held_add_b", id_ex_b, 32'h22);
        checkOutput("held_add_rd", id_ex_rd, 4);

        // lw then addi whose rt matches but is only a destination: no stall
        applyStimulus(LW_R2_0_R1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        applyStimulus(ADDI_R2_R0_5, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("rt_dest_no_stall", stall, 0);
        tick();
        checkOutput("addi5_valid", id_ex_valid, 1);
        checkOutput("addi5_simm", id_ex_simm, 32'h5);

        // addi with imm 0xFFFF
        applyStimulus(ADDI_R6_M1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("addi_simm", id_ex_simm, 32'hFFFFFFFF);
        checkOutput("addi_zimm", id_ex_zimm, 32'h0000FFFF);
        checkOutput("addi_ctrl", id_ex_ctrl, CTRL_ADDI);
        checkOutput("addi_rt", id_ex_rt, 6);

        // Unknown opcode still registers as valid with a zero bundle
        applyStimulus(UNKNOWN_3F, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("unknown_ctrl", id_ex_ctrl, 0);
        checkOutput("unknown_valid", id_ex_valid, 1);

        // ori, sw, beq decode
        applyStimulus(ORI_R7_R5, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("ori_ctrl", id_ex_ctrl, CTRL_LOGI);
        checkOutput("ori_simm", id_ex_simm, 32'hFFFF8000);
        checkOutput("ori_zimm", id_ex_zimm, 32'h00008000);
        checkOutput("ori_a", id_ex_a, 32'hDEADBEEF);
        applyStimulus(SW_R3_R5, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("sw_ctrl", id_ex_ctrl, CTRL_SW);
        checkOutput("sw_b", id_ex_b, 0);
        applyStimulus(BEQ_R5_R5, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("beq_ctrl", id_ex_ctrl, CTRL_BEQ);
        checkOutput("beq_b", id_ex_b, 32'hDEADBEEF);

        // Flush during a load-use hazard: no stall, bubble inserted
        applyStimulus(LW_R2_0_R1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        applyStimulus(ADD_R4_R2_R2, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("flush_stall", stall, 0);
        tick();
        checkOutput("flush_valid", id_ex_valid, 0);
        checkOutput("flush_ctrl", id_ex_ctrl, 0);

        // Same-cycle write-back and read of r7
        applyStimulus(ADD_R8_R7_R0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h12345678);
        tick();
        checkOutput("samecycle_a", id_ex_a, expSameCycle);
        applyStimulus(ADD_R8_R7_R0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("after_write_a", id_ex_a, 32'h12345678);

        // Writes to r0 are ignored and never forwarded
        applyStimulus(ADD_R9_R0_R0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
        tick();
        checkOutput("r0_samecycle_a", id_ex_a, 0);
        applyStimulus(ADD_R9_R0_R0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("r0_after_a", id_ex_a, 0);

        // Reset asserted mid-stall clears ID/EX and drops stall immediately
        applyStimulus(LW_R2_0_R1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        applyStimulus(ADD_R4_R2_R2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("pre_reset_stall", stall, 1);
        rst = 1'b1;
        #1;
        checkOutput("midreset_stall", stall, 0);
        checkOutput("midreset_valid", id_ex_valid, 0);
        checkOutput("midreset_ctrl", id_ex_ctrl, 0);
        checkOutput("midreset_instr", id_ex_instr, 0);
        #2;
        rst = 1'b0;

        // Register file cleared by reset
        applyStimulus(ADD_R3_R5_R0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("post_reset_r5", id_ex_a, 0);
        applyStimulus(ADD_R8_R7_R0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("post_reset_r7", id_ex_a, 0);
        checkOutput("post_reset_valid", id_ex_valid, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Parametrised instruction-decode stage with integrated ID/EX pipeline register, internal register file with optional write-back bypass, and load-use hazard detection. Sits between the IF/ID register and the execute stage. Each cycle it decodes the instruction, reads operands, generates the 9-bit control bundle and registers everything into ID/EX. On a load-use hazard or a flush it inserts a bubble instead.

## Interface
- XLEN, 32, data/register width
- NREG, 32, register count (power of two, ≥2); RAW = log2(NREG)
- IMM_W, 16, immediate field width; extended to XLEN
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_id_instr  in  32  instruction from IF/ID
- if_id_valid  in  1  IF/ID holds a real instruction
- flush  in  1  squash the instruction in ID (branch redirect)
- wb_we  in  1  write-back enable
- wb_rd  in  RAW  write-back destination
- wb_data  in  XLEN  write-back data
- stall  out  1  combinational; hold PC and IF/ID this cycle
- id_ex_valid  out  1  ID/EX holds a real instruction
- id_ex_instr  out  32  registered instruction
- id_ex_a, id_ex_b  out  XLEN  registered rs/rt operands
- id_ex_simm, id_ex_zimm  out  XLEN  sign-/zero-extended immediate
- id_ex_rs, id_ex_rt, id_ex_rd  out  RAW  registered register indices (rd = instr[15:11])
- id_ex_ctrl  out  9  {RegDst, ALUOp[1:0], ALUSrcB[1:0], MemRead, MemWrite, RegWrite, MemtoReg}

## Operation
- Decode (opcode = instr[31:26]), ctrl bits in port order:
  - 0x00 R-type: 1_10_00_0_0_1_0
  - 0x23 lw: 0_00_01_1_0_1_1
  - 0x2B sw: 0_00_01_0_1_0_0
  - 0x08 addi: 0_00_01_0_0_1_0
  - 0x0C andi / 0x0D ori: 0_11_10_0_0_1_0 (zero-extended immediate)
  - 0x04 beq: 0_01_00_0_0_0_0
  - any other: all zero
- rs = instr[25:21], rt = instr[20:16], truncated/extended to RAW bits.
- Register file: NREG×XLEN. Register 0 reads 0 and ignores writes. Write occurs at posedge when wb_we=1 and wb_rd≠0. Reads are combinational.
- uses_rt = opcode ∈ {0x00, 0x2B, 0x04}.
- Hazard: stall = if_id_valid & id_ex_valid & id_ex_ctrl[MemRead] & (id_ex_rt≠0) & ((id_ex_rt==rs) | (uses_rt & id_ex_rt==rt)) & ~flush.
- Bubble condition: stall | flush | ~if_id_valid. On a bubble, ID/EX loads all-zero (valid=0, ctrl=0, all data and index fields 0). Otherwise ID/EX loads the decoded fields and valid=1.
- Flush has priority over stall. A flush squashes ID and deasserts stall.

## Timing
- Reset: all ID/EX outputs 0 and all registers 0, asynchronously. stall=0 while in reset, because id_ex_valid=0.
- Latency: the instruction presented in cycle N appears on id_ex_* after the edge ending cycle N.
- A load-use stall lasts exactly one cycle. The bubble clears id_ex_valid, so stall drops in the next cycle and the held instruction then proceeds.
- Same-cycle write-back and read of the same register: see Configuration.
- Reset asserted mid-stall clears ID/EX immediately, and stall falls combinationally.

## Configuration
- ID_WB_BYPASS_EN defined: when wb_we=1 and wb_rd≠0 matches rs (or rt), the read returns wb_data in that same cycle (write-first). Register 0 is never bypassed.
- Not defined: reads return the pre-write stored value. Software or the hazard logic must cover the extra cycle.

## Test plan
- Reset with rst=1 mid-run → all id_ex_* = 0, stall = 0, all registers read 0.
- Write r5=0xDEADBEEF, then decode add r3,r5,r0 (0x00A01820) → id_ex_a=0xDEADBEEF, id_ex_b=0, id_ex_ctrl=0b110000010, id_ex_rd=3.
- lw r2,0(r1) followed by add r4,r2,r2 → stall=1 for one cycle, a bubble with ctrl=0 and valid=0, then the add is registered with valid=1.
- addi with imm 0xFFFF → id_ex_simm=0xFFFFFFFF and id_ex_zimm=0x0000FFFF. Unknown opcode 0x3F → ctrl=0.
- flush asserted during a load-use hazard → stall=0 and ID/EX receives a bubble.
- wb_we=1, wb_rd=7, wb_data=0x12345678 in the same cycle that rs=7 is read → with the macro: id_ex_a=0x12345678. Without it: the old value. A write to r0 leaves r0 reading 0.
